// File: rtl/spi_controller.sv
// spi_controller
//   SPI Mode-0 write-only initiator. Each accepted request is sent as one
//   16-bit frame, MSB first: bit15 = 1 (write), bits[14:8] = addr,
//   bits[7:0] = data. SCLK idles low. COPI changes on SCLK falling edges,
//   so the peripheral can sample it on rising edges.
//
// Ports
//   clk      in   system clock; all logic runs on the rising edge
//   rst      in   synchronous, active-high reset (aborts a frame in flight)
//   start    in   frame request; accepted only while busy == 0
//   addr     in   7-bit register address, captured on accept
//   data     in   8-bit register data, captured on accept
//   busy     out  frame in progress (nCS low or inter-frame gap)
//   done     out  one-cycle pulse after the gap following a frame
//   spi_out  out  packed bus {nCS, COPI, SCLK}
//
// Parameters
//   CLK_DIV  clk cycles per SCLK half-period (>= 2)
//   CS_GAP   clk cycles nCS stays high after a frame before done (>= 1)

module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic [2:0] spi_out
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int GW = $clog2(CS_GAP) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] half_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  // Only addr/data are kept. The leading write bit goes straight onto COPI
  // when the request is accepted.
  logic [14:0]   shift_reg;
  logic          ncs_reg;
  logic          copi_reg;
  logic          sclk_reg;
  logic          busy_reg;
  logic          done_reg;

  logic half_last;
  logic gap_last;
  assign half_last = (half_cnt_reg == CW'(CLK_DIV - 1));
  assign gap_last  = (gap_cnt_reg == GW'(CS_GAP - 1));

  assign spi_out = {ncs_reg, copi_reg, sclk_reg};
  assign busy    = busy_reg;
  assign done    = done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      ncs_reg      <= 1'b1;
      copi_reg     <= 1'b0;
      sclk_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // IDLE and DONE both accept a request. That allows back-to-back
        // frames with only the gap and the done cycle between them.
        IDLE, DONE: begin
          ncs_reg  <= 1'b1;
          copi_reg <= 1'b0;
          sclk_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (start) begin
            shift_reg    <= {addr, data};
            copi_reg     <= 1'b1;
            ncs_reg      <= 1'b0;
            busy_reg     <= 1'b1;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= SETUP;
          end else begin
            state_reg <= IDLE;
          end
        end

        SETUP: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            sclk_reg     <= 1'b1;
            state_reg    <= HIGH;
          end else begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end
        end

        HIGH: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            sclk_reg     <= 1'b0;
            if (bit_cnt_reg == 4'd15) begin
              state_reg <= HOLD;
            end else begin
              // Falling edge: present the next bit for the following rise.
              copi_reg    <= shift_reg[14];
              shift_reg   <= {shift_reg[13:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              state_reg   <= LOW;
            end
          end else begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end
        end

        LOW: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            sclk_reg     <= 1'b1;
            state_reg    <= HIGH;
          end else begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end
        end

        // Keep nCS low for one more half-period so the peripheral's
        // synchroniser can register the last bit before nCS rises.
        HOLD: begin
          if (half_last) begin
            half_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            ncs_reg      <= 1'b1;
            copi_reg     <= 1'b0;
            state_reg    <= GAP;
          end else begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end
        end

        GAP: begin
          if (gap_last) begin
            gap_cnt_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          ncs_reg   <= 1'b1;
          copi_reg  <= 1'b0;
          sclk_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed testbench for spi_controller (CLK_DIV=4, CS_GAP=4).
// A behavioural SPI receiver watches spi_out. It collects the bits seen at
// SCLK rising edges and commits a register write only when a complete
// 16-bit write frame ends with nCS rising.

module tb_spi_controller;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 4;
  localparam int NCS_LOW = 33 * CLK_DIV;
  localparam int LATENCY = 33 * CLK_DIV + CS_GAP + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic       busy;
  logic       done;
  logic [2:0] spi_out;

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .data    (data),
    .busy    (busy),
    .done    (done),
    .spi_out (spi_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // ---------------- receiver model ----------------
  logic [7:0]  regs [0:127];
  logic [2:0]  prev = 3'b100;
  logic [15:0] mon_sh = '0;
  int          mon_bits = 0;
  int          low_len = 0;
  int          hi_run = 0;
  int          viol = 0;
  logic [15:0] frame_q[$];
  int          bits_q[$];
  int          len_q[$];
  int          hi_q[$];

  initial for (int i = 0; i < 128; i++) regs[i] = 8'h00;

  always @(negedge clk) begin
    if (spi_out[2] && spi_out[0]) viol++;
    if (prev[2] && !spi_out[2]) begin
      hi_q.push_back(hi_run);
      mon_bits = 0;
      mon_sh   = '0;
      low_len  = 0;
    end
    if (!spi_out[2]) begin
      low_len++;
      if (!prev[0] && spi_out[0]) begin
        mon_sh = {mon_sh[14:0], spi_out[1]};
        mon_bits++;
      end
    end
    if (!prev[2] && spi_out[2]) begin
      frame_q.push_back(mon_sh);
      bits_q.push_back(mon_bits);
      len_q.push_back(low_len);
      if (mon_bits == 16 && mon_sh[15]) regs[mon_sh[14:8]] = mon_sh[7:0];
      hi_run = 0;
    end
    if (spi_out[2]) hi_run++;
    prev = spi_out;
  end

  // Issue one request and wait for done; lat counts cycles after the accept edge.
  task automatic send(input logic [6:0] a, input logic [7:0] d, output int lat);
    @(negedge clk);
    start = 1'b1; addr = a; data = d;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_bits(input int n);
    int k = 0;
    while (mon_bits != n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (mon_bits != n) check("bits_timeout", mon_bits, n);
  endtask

  int lat;
  int nf;
  int dcount;

  initial begin
    // ---- 1. reset, including a 2-cycle pulse while idle ----
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_spi_out", spi_out, 3'b100);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // ---- 2. single frame 0x04 <- 0x80 ----
    send(7'h04, 8'h80, lat);
    check("t2_latency", lat, LATENCY);
    check("t2_frame", frame_q[$], 16'h8480);
    check("t2_bits", bits_q[$], 16);
    check("t2_ncs_low", len_q[$], NCS_LOW);
    @(negedge clk);
    check("t2_idle_busy", busy, 1'b0);
    check("t2_idle_bus", spi_out, 3'b100);

    // ---- 3. start held high: back-to-back frames ----
    nf = frame_q.size();
    dcount = 0;
    @(negedge clk);
    start = 1'b1; addr = 7'h05; data = 8'h12;
    for (int k = 0; k < 3 * 200 && dcount < 3; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    start = 1'b0;
    check("t3_done_count", dcount, 3);
    check("t3_frames", frame_q.size() - nf, 3);
    check("t3_gap1", hi_q[hi_q.size()-2], CS_GAP + 1);
    check("t3_gap2", hi_q[hi_q.size()-1], CS_GAP + 1);
    for (int k = 1; k <= 3; k++) begin
      check("t3_bits", bits_q[bits_q.size()-k], 16);
      check("t3_frame", frame_q[frame_q.size()-k], 16'h8512);
    end
    repeat (3) @(negedge clk);

    // ---- 4. second request during a frame is dropped ----
    @(negedge clk);
    start = 1'b1; addr = 7'h01; data = 8'hA5;
    @(negedge clk);
    start = 1'b0; addr = 7'h00; data = 8'h00;
    wait_bits(5);
    start = 1'b1; addr = 7'h02; data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("t4_done_count", dcount, 1);
    check("t4_frame", frame_q[$], 16'h81A5);
    check("t4_reg1", regs[1], 8'hA5);
    check("t4_reg2", regs[2], 8'h00);

    // ---- 5. reset in the middle of bit 7 ----
    @(negedge clk);
    start = 1'b1; addr = 7'h03; data = 8'h77;
    @(negedge clk);
    start = 1'b0;
    wait_bits(7);
    rst = 1'b1;
    @(negedge clk);
    check("t5_spi_out", spi_out, 3'b100);
    check("t5_busy", busy, 1'b0);
    check("t5_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_partial_bits", bits_q[$], 7);
    check("t5_reg3_kept", regs[3], 8'h00);
    send(7'h03, 8'h3C, lat);
    check("t5_latency", lat, LATENCY);
    check("t5_reg3", regs[3], 8'h3C);

    // ---- 6. loopback register writes ----
    send(7'h00, 8'hF0, lat);
    send(7'h01, 8'h0F, lat);
    send(7'h02, 8'hAA, lat);
    send(7'h03, 8'h55, lat);
    send(7'h04, 8'h80, lat);
    @(negedge clk);
    check("t6_reg0", regs[0], 8'hF0);
    check("t6_reg1", regs[1], 8'h0F);
    check("t6_reg2", regs[2], 8'hAA);
    check("t6_reg3", regs[3], 8'h55);
    check("t6_reg4", regs[4], 8'h80);
    check("t6_ncs_low", len_q[$], NCS_LOW);

    check("sclk_high_while_ncs_high", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
